// File: rtl/wave_gen_if.sv
// wave_gen_if: control and sample-stream bundle for the wave_gen test-waveform
// generator.
//   enable       - generator run; low holds the generator idle
//   freq_in      - requested frequency in Hz (0..1023)
//   wave_sel     - 00 square, 01 triangle, 10 sawtooth, 11 constant midscale
//   data_out     - 12-bit unsigned sample, midscale 2048
//   sample_valid - one-cycle pulse marking a new data_out
//   period_start - one-cycle pulse on the first sample of a new period
// The master modport belongs to the controller/consumer. The slave modport
// belongs to the generator.
interface wave_gen_if;
  logic        enable;
  logic [9:0]  freq_in;
  logic [1:0]  wave_sel;
  logic [11:0] data_out;
  logic        sample_valid;
  logic        period_start;

  modport master (
    output enable, freq_in, wave_sel,
    input  data_out, sample_valid, period_start
  );

  modport slave (
    input  enable, freq_in, wave_sel,
    output data_out, sample_valid, period_start
  );
endinterface

// File: rtl/wave_gen.sv
// wave_gen: periodic 12-bit test waveform produced at a sample rate of
// clk/TICK_DIV. A modulo-SAMPLE_RATE phase accumulator advances by freq_act
// on each sample. The output therefore repeats at exactly freq_act Hz.
// Frequency and waveform selection are re-latched only on period boundaries.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - wave_gen_if.slave (enable, freq_in, wave_sel in;
//         data_out, sample_valid, period_start out, all registered)
module wave_gen #(
  parameter int unsigned TICK_DIV    = 500,
  parameter int unsigned SAMPLE_RATE = 100000,
  parameter int unsigned RECIP       = 42950
) (
  input  logic      clk,
  input  logic      rst,
  wave_gen_if.slave bus
);
  localparam int unsigned       TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [16:0]       RATE      = 17'(SAMPLE_RATE);
  localparam logic [16:0]       HALF      = 17'(SAMPLE_RATE / 2);
  localparam logic [32:0]       RECIP_W   = 33'(RECIP);
  localparam logic [11:0]       MID       = 12'd2048;
  localparam logic [11:0]       FULL      = 12'd4095;

  logic [TICK_W-1:0] tick_cnt_r;
  logic [16:0]       acc_r;
  logic [9:0]        freq_act_r;
  logic [1:0]        sel_act_r;
  logic [11:0]       data_r;
  logic              valid_r;
  logic              pstart_r;

  logic              tick_s;
  logic [16:0]       sum_s;
  logic              wrap_s;
  logic [16:0]       acc_next_s;
  logic              idle_s;
  logic              load_s;
  logic              pstart_s;
  logic [1:0]        sel_eff_s;
  logic [32:0]       prod_s;
  logic [11:0]       phase_s;
  logic [11:0]       amp_s;

  // Accumulator step, load-point detection and period-start decision.
  always_comb begin
    tick_s     = (tick_cnt_r == TICK_LAST) && bus.enable;
    sum_s      = acc_r + {7'd0, freq_act_r};
    wrap_s     = (sum_s >= RATE);
    acc_next_s = wrap_s ? (sum_s - RATE) : sum_s;
    idle_s     = (freq_act_r == 10'd0);
    load_s     = wrap_s || idle_s;
    // A parked generator that picks up a nonzero frequency starts a period at acc = 0.
    pstart_s   = wrap_s || (idle_s && (bus.freq_in != 10'd0));
    // While parked, no period is running. The output follows the incoming selection
    // so that the constant level already reflects it. Otherwise the selection in
    // force before this tick's load is used.
    sel_eff_s  = idle_s ? bus.wave_sel : sel_act_r;
    prod_s     = {16'd0, acc_next_s} * RECIP_W;
    phase_s    = 12'(prod_s >> 20);
  end

  // Phase-to-amplitude mapping for the selected waveform.
  always_comb begin
    amp_s = MID;
    case (sel_eff_s)
      2'b00: amp_s = (acc_next_s < HALF) ? FULL : 12'd0;
      2'b01: begin
        if (phase_s[11] == 1'b0) begin
          amp_s = {phase_s[10:0], 1'b0};
        end else begin
          amp_s = 12'(13'd8191 - {phase_s, 1'b0});
        end
      end
      2'b10:   amp_s = phase_s;
      2'b11:   amp_s = MID;
      default: amp_s = MID;
    endcase
  end

  // Tick divider, accumulator, active settings and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      acc_r      <= 17'd0;
      freq_act_r <= 10'd0;
      sel_act_r  <= 2'b11;
      data_r     <= MID;
      valid_r    <= 1'b0;
      pstart_r   <= 1'b0;
    end else if (!bus.enable) begin
      tick_cnt_r <= {TICK_W{1'b0}};
      acc_r      <= 17'd0;
      freq_act_r <= 10'd0;
      data_r     <= MID;
      valid_r    <= 1'b0;
      pstart_r   <= 1'b0;
    end else begin
      valid_r  <= tick_s;
      pstart_r <= tick_s && pstart_s;
      if (tick_s) begin
        tick_cnt_r <= {TICK_W{1'b0}};
        acc_r      <= acc_next_s;
        data_r     <= amp_s;
        if (load_s) begin
          freq_act_r <= bus.freq_in;
          sel_act_r  <= bus.wave_sel;
        end
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end
    end
  end

  assign bus.data_out     = data_r;
  assign bus.sample_valid = valid_r;
  assign bus.period_start = pstart_r;
endmodule
